// File: rtl/csr_host_master.sv
// CSR bus initiator: one command at a time in, strobes held across wait-request, one response out.
// Optional macro CSR_TIMEOUT_EN aborts a transfer stalled for TIMEOUT_CYCLES cycles.
module csr_host_master #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_wr_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wr_data_i,
    input  logic [DATA_W/8-1:0] cmd_be_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic                rsp_wr_o,
    output logic [DATA_W-1:0]   rsp_rd_data_o,
    output logic                rsp_err_o,
    output logic                csr_wr_o,
    output logic                csr_rd_o,
    output logic [ADDR_W-1:0]   csr_addr_o,
    output logic [DATA_W-1:0]   csr_wr_data_o,
    output logic [DATA_W/8-1:0] csr_be_o,
    input  logic                csr_wait_rq_i,
    input  logic [DATA_W-1:0]   csr_rd_data_i
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t state, next;
    logic   accept, misaligned, busy, timeout;

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    assign accept     = (state == IDLE) && cmd_valid_i;
    assign misaligned = (cmd_addr_i[1:0] != 2'b00);
    assign busy       = (state == WRITE) || (state == READ);

`ifdef CSR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // Fires on the edge that would bring the stall count up to TIMEOUT_CYCLES.
    assign timeout = busy && csr_wait_rq_i && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (accept)
            cnt <= '0;
        else if (busy && csr_wait_rq_i)
            cnt <= cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next        = state;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        csr_wr_o    = 1'b0;
        csr_rd_o    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i)
                    next = misaligned ? RESP : (cmd_wr_i ? WRITE : READ);
            end
            WRITE: begin
                csr_wr_o = 1'b1;
                if (!csr_wait_rq_i || timeout) next = RESP;
            end
            READ: begin
                csr_rd_o = 1'b1;
                if (!csr_wait_rq_i || timeout) next = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Bus fields and response fields are loaded together at accept; only read data and
    // the timeout error are updated later.
    always_ff @(posedge clk) begin
        if (reset) begin
            csr_addr_o    <= '0;
            csr_wr_data_o <= '0;
            csr_be_o      <= '0;
            rsp_wr_o      <= 1'b0;
            rsp_err_o     <= 1'b0;
            rsp_rd_data_o <= '0;
        end else begin
            if (accept) begin
                csr_addr_o    <= cmd_addr_i;
                csr_wr_data_o <= cmd_wr_data_i;
                csr_be_o      <= cmd_be_i;
                rsp_wr_o      <= cmd_wr_i;
                rsp_err_o     <= misaligned;
                rsp_rd_data_o <= '0;
            end
            if (state == READ && !csr_wait_rq_i)
                rsp_rd_data_o <= csr_rd_data_i;
            if (timeout) begin
                rsp_err_o     <= 1'b1;
                rsp_rd_data_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_csr_host_master.sv
// Randomized self-checking bench for csr_host_master; expectations come from a per-transaction model.
module tb_csr_host_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid_i, cmd_ready_o, cmd_wr_i;
    logic [3:0]  cmd_addr_i;
    logic [31:0] cmd_wr_data_i;
    logic [3:0]  cmd_be_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_wr_o, rsp_err_o;
    logic [31:0] rsp_rd_data_o;
    logic        csr_wr_o, csr_rd_o;
    logic [3:0]  csr_addr_o;
    logic [31:0] csr_wr_data_o;
    logic [3:0]  csr_be_o;
    logic        csr_wait_rq_i;
    logic [31:0] csr_rd_data_i;

    int checks = 0;
    int errors = 0;

    csr_host_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wr_data_i(cmd_wr_data_i), .cmd_be_i(cmd_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_wr_o(rsp_wr_o),
        .rsp_rd_data_o(rsp_rd_data_o), .rsp_err_o(rsp_err_o),
        .csr_wr_o(csr_wr_o), .csr_rd_o(csr_rd_o), .csr_addr_o(csr_addr_o),
        .csr_wr_data_o(csr_wr_data_o), .csr_be_o(csr_be_o),
        .csr_wait_rq_i(csr_wait_rq_i), .csr_rd_data_i(csr_rd_data_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Entered and left at posedge+1. The model: a misaligned address answers with err
    // and no bus cycle; otherwise the strobe is seen for nwait+1 cycles (or TO cycles on
    // timeout) and read data is whatever the slave drove in the non-stalled cycle.
    task automatic do_txn(input bit wr, input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input int nwait, input int nbp,
                          input logic [31:0] rdv, input bit to);
        bit          mis = (addr[1:0] != 2'b00);
        int          nstb = to ? TO : nwait + 1;
        logic [31:0] exp_rd = (wr || mis || to) ? 32'h0 : rdv;
        bit          exp_err = mis || to;

        cmd_valid_i = 1'b1; cmd_wr_i = wr; cmd_addr_i = addr;
        cmd_wr_data_i = data; cmd_be_i = be;
        chk("cmd_ready_idle", cmd_ready_o, 1);
        step();
        cmd_valid_i = 1'b0;
        cmd_wr_data_i = $urandom; cmd_addr_i = 4'($urandom); cmd_be_i = 4'($urandom);
        if (!mis) begin
            for (int i = 0; i < nstb; i++) begin
                chk("csr_wr", csr_wr_o, wr);
                chk("csr_rd", csr_rd_o, !wr);
                chk("csr_addr", csr_addr_o, addr);
                chk("csr_wdata", csr_wr_data_o, data);
                chk("csr_be", csr_be_o, be);
                chk("cmd_ready_busy", cmd_ready_o, 0);
                chk("rsp_valid_busy", rsp_valid_o, 0);
                csr_wait_rq_i = to ? 1'b1 : (i < nwait);
                csr_rd_data_i = (!to && i == nwait) ? rdv : $urandom;
                step();
            end
            csr_wait_rq_i = 1'b0;
        end
        for (int j = 0; j <= nbp; j++) begin
            chk("rsp_valid", rsp_valid_o, 1);
            chk("rsp_wr", rsp_wr_o, wr);
            chk("rsp_err", rsp_err_o, exp_err);
            chk("rsp_rdata", rsp_rd_data_o, exp_rd);
            chk("strobes_resp", {csr_wr_o, csr_rd_o}, 0);
            chk("cmd_ready_resp", cmd_ready_o, 0);
            rsp_ready_i = (j == nbp);
            csr_wait_rq_i = 1'(($urandom));
            step();
        end
        rsp_ready_i = 1'b0;
        csr_wait_rq_i = 1'b0;
        chk("rsp_valid_done", rsp_valid_o, 0);
        chk("cmd_ready_done", cmd_ready_o, 1);
    endtask

    initial begin
        reset = 1'b1; cmd_valid_i = 1'b0; cmd_wr_i = 1'b0; cmd_addr_i = '0;
        cmd_wr_data_i = '0; cmd_be_i = '0; rsp_ready_i = 1'b0;
        csr_wait_rq_i = 1'b0; csr_rd_data_i = '0;
        step(); step();
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_fields", {rsp_wr_o, rsp_err_o, rsp_rd_data_o}, 0);
        chk("rst_strobes", {csr_wr_o, csr_rd_o}, 0);
        chk("rst_bus_fields", {csr_addr_o, csr_wr_data_o, csr_be_o}, 0);
        reset = 1'b0;
        step();

        // Directed cases from the plan.
        do_txn(1, 4'h0, 32'hA5A5_1234, 4'hF, 2, 0, 32'h0, 0);
        do_txn(0, 4'h4, 32'h0, 4'hF, 2, 0, 32'h0000_00C3, 0);
        do_txn(0, 4'h6, 32'h0, 4'hF, 0, 0, 32'h0, 0);
        do_txn(1, 4'hC, 32'hDEAD_BEEF, 4'h0, 0, 5, 32'h0, 0);
        do_txn(0, 4'h8, 32'h0, 4'h3, 0, 0, 32'h1234_5678, 0);

        // Randomized traffic; stalls kept below the timeout so no abort is expected.
        for (int n = 0; n < 60; n++) begin
            logic [3:0] a = 4'($urandom);
            do_txn(1'($urandom), a, $urandom, 4'($urandom),
                   int'($urandom_range(0, TO - 2)), int'($urandom_range(0, 3)), $urandom, 0);
        end

        // Reset in the middle of a stalled read: no response may appear afterwards.
        cmd_valid_i = 1'b1; cmd_wr_i = 1'b0; cmd_addr_i = 4'h4;
        step();
        cmd_valid_i = 1'b0;
        csr_wait_rq_i = 1'b1;
        chk("mid_rd_strobe", csr_rd_o, 1);
        step();
        chk("mid_rd_held", csr_rd_o, 1);
        reset = 1'b1;
        step();
        chk("mid_rst_rd", csr_rd_o, 0);
        chk("mid_rst_rsp_valid", rsp_valid_o, 0);
        chk("mid_rst_cmd_ready", cmd_ready_o, 1);
        reset = 1'b0;
        csr_wait_rq_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_no_rsp", rsp_valid_o, 0);
            chk("post_rst_no_strobe", {csr_wr_o, csr_rd_o}, 0);
        end

`ifdef CSR_TIMEOUT_EN
        do_txn(1, 4'h8, 32'h0BAD_F00D, 4'hF, 0, 1, 32'h0, 1);
        do_txn(0, 4'h0, 32'h0, 4'hF, 0, 0, 32'hFFFF_FFFF, 1);
`endif
        do_txn(0, 4'h4, 32'h0, 4'hF, 1, 0, 32'h0F0F_0F0F, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
